// File: rtl/seg_frame_sequencer.sv
// Frame-level sequencer for hand segmentation: pixel counting, method select, background capture.
// Optional build macro SEGSEQ_SETTLE_EN adds exposure-settle frames before each background capture.
module seg_frame_sequencer #(
  parameter int unsigned FRAME_PIXELS  = 19200,
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned SETTLE_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic              mode_bg,
  input  logic              recapture,
  output logic              bg_we,
  output logic              bg_rd,
  output logic [ADDR_W-1:0] bg_addr,
  output logic              seg_sel,
  output logic              seg_valid,
  output logic              bg_ready,
  output logic              frame_done,
  output logic              overrun,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSkin    = 3'd1,
    StSettle  = 3'd2,
    StCapture = 3'd3,
    StCompare = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(FRAME_PIXELS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              sel_q, sel_d;
  logic              sv_q, sv_d;
  logic              in_frame;
  logic              pix_take;

`ifdef SEGSEQ_SETTLE_EN
  localparam int unsigned SettleW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [SettleW-1:0] LastSettle = SettleW'(SETTLE_FRAMES - 1);

  logic [SettleW-1:0] settle_q, settle_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
    end else begin
      settle_q <= settle_d;
    end
  end
`else
  logic unused_settle;
  assign unused_settle = ^SETTLE_FRAMES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sel_q   <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      sel_q   <= sel_d;
      sv_q    <= sv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q | recapture;
    ready_d  = ready_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    sel_d    = sel_q;
`ifdef SEGSEQ_SETTLE_EN
    settle_d = settle_q;
`endif
    in_frame = (state_q == StSkin) || (state_q == StCapture) || (state_q == StCompare);
    // A pixel arriving with sof belongs to neither frame.
    pix_take = pix_valid && !sof && in_frame;
    sv_d     = pix_take && ((state_q == StSkin) || (state_q == StCompare));

    if (sof) begin
      cnt_d = '0;
      if (in_frame && (cnt_q != '0)) begin
        ovr_d = 1'b1;
      end
      if (!mode_bg) begin
        state_d = StSkin;
        sel_d   = 1'b0;
`ifdef SEGSEQ_SETTLE_EN
      end else if ((state_q == StSettle) && !(pend_q || recapture)) begin
        if (settle_q == LastSettle) begin
          state_d = StCapture;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
`endif
      end else if (!ready_q || pend_q || recapture) begin
        ready_d = 1'b0;
        pend_d  = 1'b0;
`ifdef SEGSEQ_SETTLE_EN
        state_d  = StSettle;
        settle_d = '0;
`else
        state_d = StCapture;
`endif
      end else begin
        state_d = StCompare;
        sel_d   = 1'b1;
      end
    end else if (pix_take) begin
      if (cnt_q == LastPix) begin
        cnt_d   = '0;
        state_d = StIdle;
        done_d  = 1'b1;
        if (state_q == StCapture) begin
          ready_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  assign bg_we      = (state_q == StCapture) && pix_valid && !sof;
  assign bg_rd      = (state_q == StCompare) && pix_valid && !sof;
  assign bg_addr    = cnt_q;
  assign seg_sel    = sel_q;
  assign seg_valid  = sv_q;
  assign bg_ready   = ready_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign state      = state_q;

endmodule

// File: tb/tb_seg_frame_sequencer.sv
// Directed bench for seg_frame_sequencer with a 16-pixel frame; honours SEGSEQ_SETTLE_EN if defined.
module tb_seg_frame_sequencer;

  localparam int unsigned Frame = 16;
  localparam int unsigned AddrW = 4;
  localparam logic [2:0] SIdle = 3'd0, SSkin = 3'd1, SSettle = 3'd2, SCap = 3'd3, SCmp = 3'd4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sof = 1'b0;
  logic             pix_valid = 1'b0;
  logic             mode_bg = 1'b0;
  logic             recapture = 1'b0;
  logic             bg_we, bg_rd, seg_sel, seg_valid, bg_ready, frame_done, overrun;
  logic [AddrW-1:0] bg_addr;
  logic [2:0]       state;

  int   n_vec = 0;
  int   n_err = 0;
  logic sel_exp = 1'b0;
  logic ovr_exp = 1'b0;

  seg_frame_sequencer #(
    .FRAME_PIXELS (Frame),
    .ADDR_W       (AddrW),
    .SETTLE_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sof       (sof),
    .pix_valid (pix_valid),
    .mode_bg   (mode_bg),
    .recapture (recapture),
    .bg_we     (bg_we),
    .bg_rd     (bg_rd),
    .bg_addr   (bg_addr),
    .seg_sel   (seg_sel),
    .seg_valid (seg_valid),
    .bg_ready  (bg_ready),
    .frame_done(frame_done),
    .overrun   (overrun),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen mid-cycle.
  task automatic drive(input logic s, input logic pv, input logic rc);
    sof       = s;
    pix_valid = pv;
    recapture = rc;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input logic mb, input logic rc0, input logic pv0, input int npix,
                          input logic [2:0] est, input int rc_idx);
    mode_bg = mb;
    drive(1'b1, pv0, rc0);
    check_eq("sof_bg_we", 32'(bg_we), 32'd0);
    check_eq("sof_bg_rd", 32'(bg_rd), 32'd0);
    tick();
    if (est == SSkin) sel_exp = 1'b0;
    else if (est == SCmp) sel_exp = 1'b1;
    for (int i = 0; i < npix; i++) begin
      drive(1'b0, 1'b1, logic'(i == rc_idx));
      check_eq("state", 32'(state), 32'(est));
      check_eq("bg_we", 32'(bg_we), 32'(est == SCap));
      check_eq("bg_rd", 32'(bg_rd), 32'(est == SCmp));
      check_eq("bg_addr", 32'(bg_addr), (est == SSettle) ? 32'd0 : 32'(i));
      check_eq("seg_sel", 32'(seg_sel), 32'(sel_exp));
      check_eq("seg_valid", 32'(seg_valid), 32'(i > 0 && (est == SSkin || est == SCmp)));
      check_eq("frame_done_mid", 32'(frame_done), 32'd0);
      if (i == 0) begin
        check_eq("overrun", 32'(overrun), 32'(ovr_exp));
        if (est == SCap || est == SSettle) check_eq("bg_ready_acq", 32'(bg_ready), 32'd0);
      end
      tick();
    end
  endtask

  task automatic frame_end(input logic [2:0] est, input logic rdy);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("end_state", 32'(state), 32'(SIdle));
    check_eq("frame_done", 32'(frame_done), 32'd1);
    check_eq("bg_ready", 32'(bg_ready), 32'(rdy));
    check_eq("end_seg_valid", 32'(seg_valid), 32'(est == SSkin || est == SCmp));
    check_eq("end_addr", 32'(bg_addr), 32'd0);
    check_eq("end_overrun", 32'(overrun), 32'(ovr_exp));
    tick();
    drive(1'b0, 1'b1, 1'b0);
    check_eq("done_pulse", 32'(frame_done), 32'd0);
    check_eq("stray_we", 32'(bg_we), 32'd0);
    check_eq("stray_rd", 32'(bg_rd), 32'd0);
    check_eq("stray_state", 32'(state), 32'(SIdle));
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check_eq("stray_seg_valid", 32'(seg_valid), 32'd0);
    check_eq("stray_addr", 32'(bg_addr), 32'd0);
  endtask

  // Background acquisition: settle frames first when that feature is built in.
  task automatic do_acq(input logic rc0, input int npix);
`ifdef SEGSEQ_SETTLE_EN
    do_frame(1'b1, rc0, 1'b0, Frame, SSettle, -1);
    do_frame(1'b1, 1'b0, 1'b0, Frame, SSettle, -1);
    do_frame(1'b1, 1'b0, 1'b0, npix, SCap, -1);
`else
    do_frame(1'b1, rc0, 1'b0, npix, SCap, -1);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_addr"}, 32'(bg_addr), 32'd0);
    check_eq({tag, "_we"}, 32'(bg_we), 32'd0);
    check_eq({tag, "_rd"}, 32'(bg_rd), 32'd0);
    check_eq({tag, "_sel"}, 32'(seg_sel), 32'd0);
    check_eq({tag, "_sv"}, 32'(seg_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(bg_ready), 32'd0);
    check_eq({tag, "_done"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #3;
    check_all_zero("rst");
    tick();
    rst = 1'b0;

    // Idle ignores pixels.
    drive(1'b0, 1'b1, 1'b0);
    check_eq("idle_we", 32'(bg_we), 32'd0);
    check_eq("idle_rd", 32'(bg_rd), 32'd0);
    check_eq("idle_state", 32'(state), 32'(SIdle));
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check_eq("idle_seg_valid", 32'(seg_valid), 32'd0);

    do_frame(1'b0, 1'b0, 1'b0, Frame, SSkin, -1);
    frame_end(SSkin, 1'b0);

    do_acq(1'b0, Frame);
    frame_end(SCap, 1'b1);
    do_frame(1'b1, 1'b0, 1'b0, Frame, SCmp, -1);
    frame_end(SCmp, 1'b1);

    // Recapture mid-compare: frame finishes as compare, next sof re-acquires.
    do_frame(1'b1, 1'b0, 1'b0, Frame, SCmp, 7);
    frame_end(SCmp, 1'b1);
    do_acq(1'b0, Frame);
    frame_end(SCap, 1'b1);

    // Recapture coincident with sof.
    do_acq(1'b1, Frame);
    frame_end(SCap, 1'b1);

    // Short capture frame: overrun, then full re-capture from address 0.
    do_acq(1'b1, 9);
    ovr_exp = 1'b1;
    do_acq(1'b0, Frame);
    frame_end(SCap, 1'b1);
    do_frame(1'b1, 1'b0, 1'b0, Frame, SCmp, -1);
    frame_end(SCmp, 1'b1);
    do_frame(1'b0, 1'b0, 1'b0, Frame, SSkin, -1);
    frame_end(SSkin, 1'b1);

    // Pixel coincident with sof is dropped.
    do_frame(1'b1, 1'b0, 1'b1, Frame, SCmp, -1);
    frame_end(SCmp, 1'b1);

    // Asynchronous reset in the middle of a capture.
    do_acq(1'b1, 5);
    drive(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    pix_valid = 1'b0;
    ovr_exp   = 1'b0;
    sel_exp   = 1'b0;
    tick();
    rst = 1'b0;
    do_acq(1'b0, Frame);
    frame_end(SCap, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_frame_sequencer.md
# seg_frame_sequencer

Frame-level controller for the hand-segmentation stage. Tracks pixel position within each camera frame and selects skin-colour or background-difference segmentation. In background-difference mode it sequences a one-frame background capture into the background luma RAM, then drives read addressing for per-pixel comparison. It also flags malformed frames. It sits between the camera pixel stream and the segmentation datapath and background RAM, and supplies the write/read enables, address and result-valid strobe they need.

## Interface
- FRAME_PIXELS, 19200, pixels per frame (160x120).
- ADDR_W, 15, width of pixel counter / RAM address; must satisfy 2^ADDR_W >= FRAME_PIXELS.
- SETTLE_FRAMES, 2, frames discarded before background capture; used only with SEGSEQ_SETTLE_EN.
- clk  in  1  pixel clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sof  in  1  one-cycle start-of-frame pulse; precedes the frame's first pixel.
- pix_valid  in  1  current input pixel valid.
- mode_bg  in  1  1 = background-difference method, 0 = skin-colour method; sampled only at sof.
- recapture  in  1  one-cycle request to discard and re-acquire the background.
- bg_we  out  1  background RAM write enable (combinational).
- bg_rd  out  1  background RAM read enable (combinational).
- bg_addr  out  ADDR_W  current pixel index, registered counter.
- seg_sel  out  1  result mux select: 1 = background difference, 0 = skin colour.
- seg_valid  out  1  segmentation output valid, registered.
- bg_ready  out  1  a complete background frame is stored.
- frame_done  out  1  one-cycle pulse after the last pixel of a processed frame.
- overrun  out  1  sticky: sof arrived mid-frame.
- state  out  3  FSM state: IDLE=0, SKIN=1, SETTLE=2, CAPTURE=3, COMPARE=4.

## Operation
- Reset: state=IDLE, counter=0, recapture-pending=0, settle count=0. All outputs 0.
- Frame decision on every sof, from any state. Evaluated in this order:
  - mode_bg=0 -> SKIN.
  - mode_bg=1 with (bg_ready=0 or recapture pending) -> clear bg_ready and pending flag, enter SETTLE (macro on) or CAPTURE (macro off).
  - mode_bg=1 otherwise -> COMPARE.
  - Counter cleared to 0 on every sof.
- recapture sets the pending flag. recapture coincident with sof is honoured at that sof.
- IDLE: pix_valid ignored; all enables 0.
- SKIN: seg_sel=0; each pix_valid increments counter.
- CAPTURE: bg_we = pix_valid; bg_addr = counter; each pix_valid increments counter.
- COMPARE: seg_sel=1; bg_rd = pix_valid; bg_addr = counter; each pix_valid increments counter.
- End of frame: pix_valid with counter == FRAME_PIXELS-1 in SKIN/CAPTURE/COMPARE:
  - counter -> 0, state -> IDLE, frame_done pulses.
  - In CAPTURE, bg_ready also sets.
  - Pixels after this, before the next sof, are ignored.
- pix_valid coincident with sof is dropped; it belongs to neither frame.
- Short frame: sof with counter != 0 in SKIN/CAPTURE/COMPARE sets overrun. The new frame starts normally; an interrupted CAPTURE leaves bg_ready=0 and re-captures.
- overrun clears only on rst.
- mode_bg changes mid-frame have no effect until the next sof.
- seg_sel is registered and holds its value in IDLE.

## Timing
- bg_we/bg_rd are combinational from state and pix_valid, in the same cycle as the pixel; bg_addr is valid in that cycle.
- seg_valid = pix_valid delayed 1 cycle, gated by state SKIN or COMPARE. This matches the 1-cycle registered segmentation decision and synchronous RAM read.
- frame_done and bg_ready assert 1 cycle after the last-pixel cycle.
- State change is visible 1 cycle after sof; the earliest usable pixel is the cycle after sof.
- Async rst forces reset values immediately, including mid-capture; bg_ready returns to 0.

## Configuration
- SEGSEQ_SETTLE_EN defined:
  - A background acquisition enters SETTLE first.
  - SETTLE counts sof pulses and processes no pixels.
  - On the SETTLE_FRAMES-th following sof it enters CAPTURE directly, counter 0, so exposure has settled before capture.
  - mode_bg=0 at any sof aborts to SKIN and leaves bg_ready=0.
- Not defined: SETTLE state and settle counter are absent; acquisition goes straight to CAPTURE; state value 2 is never produced.

## Test plan
Bench uses FRAME_PIXELS=16, ADDR_W=4.
- rst, then mode_bg=0, sof, 16 pix_valid:
  - state=1 and seg_sel=0; bg_we=0 and bg_rd=0 throughout.
  - seg_valid high 16 cycles, lagging pix_valid by 1; frame_done one pulse.
- mode_bg=1, two frames (macro off):
  - Frame 1: bg_we high 16 cycles with bg_addr 0..15; bg_ready=1 after the last pixel.
  - Frame 2: state=4, seg_sel=1, bg_rd with addr 0..15.
- Capture frame with sof after 9 pixels:
  - overrun=1, bg_ready=0, next frame re-captures from addr 0.
  - overrun stays 1 through later frames until rst.
- recapture pulsed mid-COMPARE frame: the current frame completes as COMPARE, next sof clears bg_ready and enters CAPTURE. recapture coincident with sof behaves identically.
- pix_valid coincident with sof, then 16 pixels: the coincident pixel produces no enable; addresses 0..15 follow.
- With SEGSEQ_SETTLE_EN, SETTLE_FRAMES=2: mode_bg=1 gives two frames at state=2 with no bg_we, then CAPTURE on the next sof. rst mid-CAPTURE returns all outputs to 0.
